// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - two-stage pipelined immediate extender with valid/ready handshakes
// S1 holds the raw immediate and mode, S2 holds the extended result and error flag.
module ext_pipe #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] imm,
  input  logic [2:0]       EOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] ext,
  output logic             err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int PAD = OUT_W - IMM_W;

  localparam logic [2:0] MODE_SX    = 3'b000;
  localparam logic [2:0] MODE_ZX    = 3'b001;
  localparam logic [2:0] MODE_HI    = 3'b010;
  localparam logic [2:0] MODE_SX_S2 = 3'b011;
  localparam logic [2:0] MODE_ZX_S2 = 3'b100;
  localparam logic [2:0] MODE_B8    = 3'b101;

  logic             s1_valid;
  logic [IMM_W-1:0] s1_imm;
  logic [2:0]       s1_eop;
  logic             s2_valid;
  logic             s1_load;
  logic             s2_load;

  logic [OUT_W-1:0] sx;
  logic [OUT_W-1:0] zx;
  logic [OUT_W-1:0] hi;
  logic [OUT_W-1:0] b8;
  logic [OUT_W-1:0] ext_d;
  logic             err_d;

  assign out_valid = s2_valid;
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign s1_load   = in_valid && in_ready;

  assign sx = {{PAD{s1_imm[IMM_W-1]}}, s1_imm};
  assign zx = {{PAD{1'b0}}, s1_imm};
  assign hi = {s1_imm, {PAD{1'b0}}};

  // Narrow immediates have no byte to pick; fall back to a plain sign-extend.
  generate
    if (IMM_W >= 8) begin : g_b8
      assign b8 = {{(OUT_W-8){s1_imm[7]}}, s1_imm[7:0]};
    end else begin : g_b8_narrow
      assign b8 = sx;
    end
  endgenerate

  always_comb begin
    ext_d = '0;
    err_d = 1'b0;
    case (s1_eop)
      MODE_SX:    ext_d = sx;
      MODE_ZX:    ext_d = zx;
      MODE_HI:    ext_d = hi;
      MODE_SX_S2: ext_d = sx << 2;
      MODE_ZX_S2: ext_d = zx << 2;
      MODE_B8:    ext_d = b8;
      default:    err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_eop   <= '0;
      s2_valid <= 1'b0;
      ext      <= '0;
      err      <= 1'b0;
      done_cnt <= '0;
    end else begin
      if (s1_load) begin
        s1_imm   <= imm;
        s1_eop   <= EOp;
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        ext      <= ext_d;
        err      <= err_d;
        s2_valid <= 1'b1;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
      if (s2_valid && out_ready)
        done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, two-stage pipelined immediate extender. It widens an IMM_W-bit immediate to OUT_W bits under a 3-bit mode select.
- Uses valid/ready handshakes on both sides, so it can sit between decode and execute with stalls.
- Adds two things the single-cycle extender lacks: illegal-mode flagging and a wrapping count of completed transfers.

Parameters:
- IMM_W, 16: immediate input width. Legal range 2..OUT_W-2.
- OUT_W, 32: extended output width. Must be ≥ IMM_W+2.
- CNT_W, 16: width of the completed-transfer counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream presents imm/EOp
- in_ready  output  1  block can accept this cycle
- imm  input  IMM_W  immediate to extend
- EOp  input  3  extension mode
- out_valid  output  1  ext/err hold a result
- out_ready  input  1  downstream accepts the result
- ext  output  OUT_W  extended result
- err  output  1  result came from an illegal EOp
- done_cnt  output  CNT_W  number of output handshakes completed, wraps

Behaviour:
- Reset (asynchronous, active-high, any time including mid-transfer):
  - Both stage valids clear; in-flight data is discarded.
  - out_valid=0, ext=0, err=0, done_cnt=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Transfers:
  - Input transfer occurs on a clk edge with in_valid&&in_ready.
  - Output transfer occurs on a clk edge with out_valid&&out_ready.
- Stage 1 (S1): registers imm and EOp on input transfer; s1_valid set.
- Stage 2 (S2): computes the extension from S1 contents and registers ext/err; drives out_valid = s2_valid.
- Advance rules:
  - S2 loads when s1_valid && (!s2_valid || out_ready).
  - S1 loads when in_valid && (!s1_valid || S1 advances this cycle).
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is combinational from out_ready; there is no combinational path from in_valid.
- Latency: result is visible 2 cycles after input transfer when not stalled (accepted at edge N, out_valid high after edge N+1).
- Throughput: 1 per cycle with out_ready held high.
- Capacity: 2 items. With out_ready=0, exactly two transfers are accepted, then in_ready=0.
- Stall: ext/err/out_valid hold stable while out_valid&&!out_ready. No data loss or duplication.
- Simultaneous output and input transfer on a full pipe: both stages advance in the same edge.
- Modes (result truncated to OUT_W, shifts are logical left, zeros fill in):
  - 000 sign-extend imm
  - 001 zero-extend imm
  - 010 imm placed in the high bits: imm << (OUT_W-IMM_W)
  - 011 sign-extend, then <<2
  - 100 zero-extend, then <<2
  - 101 sign-extend imm[7:0] only. Requires IMM_W ≥ 8; the upper imm bits are ignored.
  - 110, 111 illegal: ext=0, err=1. These still complete a normal handshake.
- err is 0 for all legal modes.
- done_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0. Input transfers do not affect it.

Test Plan:
- Reset, then with out_ready=1 send these in back-to-back cycles:
  - imm=16'h8001, EOp=000 → ext=32'hFFFF8001
  - imm=16'h8001, EOp=001 → ext=32'h00008001
  - imm=16'h1234, EOp=010 → ext=32'h12340000
  - Results appear on consecutive cycles, first one 2 cycles after acceptance, err=0.
- Shift modes:
  - imm=16'hFFFF, EOp=011 → 32'hFFFFFFFC
  - EOp=100 → 32'h0003FFFC
  - imm=16'h0080, EOp=101 → 32'hFFFFFF80
- Illegal mode: EOp=110 and EOp=111 with imm=16'hABCD → ext=0, err=1, handshake completes, done_cnt increments.
- Backpressure: hold out_ready=0 and in_valid=1.
  - Exactly 2 inputs are accepted, then in_ready=0 and ext stays stable.
  - Release out_ready: outputs appear in order with no loss or duplication, and in_ready returns to 1 in the same cycle.
- Reset mid-stream: assert reset asynchronously, between clock edges, with both stages full.
  - out_valid, ext, err and done_cnt go to 0 immediately.
  - Old data never appears after reset deasserts.
- Counter wrap with CNT_W=4: complete 17 transfers → done_cnt reads 1. Parameter sweep IMM_W=12, OUT_W=24: imm=12'h800, EOp=000 → 24'hFFF800; EOp=010 → 24'h800000.
